// File: rtl/td4_pkg.sv
// td4_pkg: shared opcodes, source-mux codes and FSM state encoding for the TD4 sequencer.
// Optional feature macro used elsewhere in this slice: TD4_SINGLE_STEP_EN.
package td4_pkg;
    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_A  = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_B  = 4'b0111;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_OUT_IM = 4'b1011;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_IN   = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    typedef enum logic {ST_FETCH = 1'b0, ST_EXEC = 1'b1} state_t;
endpackage

// File: rtl/td4_sequencer_if.sv
// td4_sequencer_if: bus between the TD4 sequencer and ROM / datapath.
//   master (sequencer): in RUN, ROM_DATA, CARRY[, STEP]; out ROM_ADDR, IMM, SEL, LD_A_N, LD_B_N, LD_OUT_N, CFLAG
//   slave  (ROM/datapath/bench): the mirror image.
//   STEP exists only when TD4_SINGLE_STEP_EN is defined.
interface td4_sequencer_if #(parameter int PC_W = 4, parameter int DATA_W = 4);
    logic              RUN;
    logic [7:0]        ROM_DATA;
    logic              CARRY;
`ifdef TD4_SINGLE_STEP_EN
    logic              STEP;
`endif
    logic [PC_W-1:0]   ROM_ADDR;
    logic [DATA_W-1:0] IMM;
    logic [1:0]        SEL;
    logic              LD_A_N;
    logic              LD_B_N;
    logic              LD_OUT_N;
    logic              CFLAG;

    modport master (
        input  RUN, ROM_DATA, CARRY,
`ifdef TD4_SINGLE_STEP_EN
        input  STEP,
`endif
        output ROM_ADDR, IMM, SEL, LD_A_N, LD_B_N, LD_OUT_N, CFLAG
    );

    modport slave (
        output RUN, ROM_DATA, CARRY,
`ifdef TD4_SINGLE_STEP_EN
        output STEP,
`endif
        input  ROM_ADDR, IMM, SEL, LD_A_N, LD_B_N, LD_OUT_N, CFLAG
    );
endinterface

// File: rtl/td4_decode.sv
// td4_decode: combinational opcode decode to source select, active-low load strobes and jump flags.
//   in  op[3:0]
//   out sel[1:0], ld_a_n, ld_b_n, ld_out_n, is_jmp, is_jnc
//   Jumps and NOPs select A and assert no strobe.
module td4_decode
    import td4_pkg::*;
(
    input  logic [3:0] op,
    output logic [1:0] sel,
    output logic       ld_a_n,
    output logic       ld_b_n,
    output logic       ld_out_n,
    output logic       is_jmp,
    output logic       is_jnc
);
    always_comb begin
        sel      = SEL_A;
        ld_a_n   = 1'b1;
        ld_b_n   = 1'b1;
        ld_out_n = 1'b1;
        is_jmp   = op == OP_JMP;
        is_jnc   = op == OP_JNC;
        case (op)
            OP_ADD_A:  begin sel = SEL_A;    ld_a_n   = 1'b0; end
            OP_MOV_AB: begin sel = SEL_B;    ld_a_n   = 1'b0; end
            OP_IN_A:   begin sel = SEL_IN;   ld_a_n   = 1'b0; end
            OP_MOV_A:  begin sel = SEL_ZERO; ld_a_n   = 1'b0; end
            OP_MOV_BA: begin sel = SEL_A;    ld_b_n   = 1'b0; end
            OP_ADD_B:  begin sel = SEL_B;    ld_b_n   = 1'b0; end
            OP_IN_B:   begin sel = SEL_IN;   ld_b_n   = 1'b0; end
            OP_MOV_B:  begin sel = SEL_ZERO; ld_b_n   = 1'b0; end
            OP_OUT_B:  begin sel = SEL_B;    ld_out_n = 1'b0; end
            OP_OUT_IM: begin sel = SEL_ZERO; ld_out_n = 1'b0; end
            default:   ;
        endcase
    end
endmodule

// File: rtl/td4_sequencer.sv
// td4_sequencer: two-phase fetch/execute controller for the TD4 CPU (PC, IR, carry flag).
//   CLK, RSTB (sync, active-low)
//   bus.master: RUN, ROM_DATA, CARRY[, STEP] in; ROM_ADDR, IMM, SEL, LD_A_N, LD_B_N, LD_OUT_N, CFLAG out
//   Macro TD4_SINGLE_STEP_EN: FETCH additionally waits for STEP=1.
module td4_sequencer
    import td4_pkg::*;
#(
    parameter int PC_W   = 4,
    parameter int DATA_W = 4
)(
    input  logic              CLK,
    input  logic              RSTB,
    td4_sequencer_if.master   bus
);
    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [7:0]        ir;
    logic              cflag;
    logic [1:0]        d_sel;
    logic              d_ld_a_n, d_ld_b_n, d_ld_out_n, d_jmp, d_jnc;
    logic              go;
    logic              exec;

`ifdef TD4_SINGLE_STEP_EN
    assign go = bus.RUN && bus.STEP;
`else
    assign go = bus.RUN;
`endif

    td4_decode u_decode (
        .op       (ir[7:4]),
        .sel      (d_sel),
        .ld_a_n   (d_ld_a_n),
        .ld_b_n   (d_ld_b_n),
        .ld_out_n (d_ld_out_n),
        .is_jmp   (d_jmp),
        .is_jnc   (d_jnc)
    );

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            state <= ST_FETCH;
            pc    <= '0;
            ir    <= 8'h00;
            cflag <= 1'b0;
        end else if (state == ST_FETCH) begin
            if (go) begin
                ir    <= bus.ROM_DATA;
                state <= ST_EXEC;
            end
        end else begin
            state <= ST_FETCH;
            cflag <= bus.CARRY;
            // JNC tests the flag as it stood before this EXEC's carry is captured
            pc    <= (d_jmp || (d_jnc && !cflag)) ? ir[PC_W-1:0] : pc + 1'b1;
        end
    end

    // Outputs depend only on registered state; decode is gated so strobes fire in EXEC only
    assign exec         = state == ST_EXEC;
    assign bus.ROM_ADDR = pc;
    assign bus.IMM      = ir[DATA_W-1:0];
    assign bus.CFLAG    = cflag;
    assign bus.SEL      = exec ? d_sel : SEL_A;
    assign bus.LD_A_N   = exec ? d_ld_a_n : 1'b1;
    assign bus.LD_B_N   = exec ? d_ld_b_n : 1'b1;
    assign bus.LD_OUT_N = exec ? d_ld_out_n : 1'b1;
endmodule
